// File: rtl/branch_resolve_update_if.sv
// Fetch/execute-facing handshake bundle for branch_resolve_update.
// master: the fetch/execute side driving issues and resolves.
// slave:  the resolve/update block.
interface branch_resolve_update_if #(
    parameter int unsigned BHT_IDX_W = 4
);
    logic                 issue_valid;
    logic [2:0]           issue_type;
    logic [BHT_IDX_W-1:0] issue_idx;
    logic                 issue_pred;
    logic                 issue_ready;
    logic                 resolve_valid;
    logic                 resolve_taken;

    modport master (
        output issue_valid, issue_type, issue_idx, issue_pred,
        output resolve_valid, resolve_taken,
        input  issue_ready
    );

    modport slave (
        input  issue_valid, issue_type, issue_idx, issue_pred,
        input  resolve_valid, resolve_taken,
        output issue_ready
    );
endinterface

// File: rtl/branch_resolve_update.sv
// Branch resolution and BHT training.
// Issued branches are queued in order; execute resolves the oldest one,
// which trains a 2-bit saturating counter and may raise a one-cycle
// mispredict pulse that also flushes every younger in-flight branch.
module branch_resolve_update #(
    parameter int unsigned BHT_IDX_W  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [BHT_IDX_W-1:0]          lookup_idx,
    output logic                          lookup_taken,
    branch_resolve_update_if.slave        bus,
    output logic                          mispredict,
    output logic [$clog2(FIFO_DEPTH):0]   inflight,
    output logic                          resolve_err
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned BHT_N = 1 << BHT_IDX_W;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef struct packed {
        logic [2:0]           btype;
        logic [BHT_IDX_W-1:0] idx;
        logic                 pred;
    } entry_t;

    entry_t               fifo_q [FIFO_DEPTH];
    logic [1:0]           bht_q  [BHT_N];
    logic [PTR_W-1:0]     rd_ptr_q;
    logic [PTR_W-1:0]     wr_ptr_q;
    logic [PTR_W:0]       count_q;

    entry_t               head;
    entry_t               new_entry;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 is_branch;
    logic                 head_cond;
    logic                 do_pop;
    logic                 do_push;
    logic                 flush;

    // Combinational lookup, handshake and push/pop/flush decisions
    always_comb begin
        head         = fifo_q[rd_ptr_q];
        fifo_empty   = (count_q == '0);
        fifo_full    = (count_q == FULL_CNT);
        // types 100..111 are exactly the ones with the MSB set
        is_branch    = bus.issue_type[2];
        head_cond    = head.btype[2] & (head.btype[1:0] != 2'b00);
        lookup_taken = bht_q[lookup_idx][1];
        // a same-edge pop frees the slot, so a full queue still accepts
        bus.issue_ready = ~fifo_full | bus.resolve_valid;
        do_pop       = bus.resolve_valid & ~fifo_empty;
        flush        = do_pop & head_cond & (bus.resolve_taken != head.pred);
        // a same-edge issue counts as younger than the mispredicted head
        do_push      = bus.issue_valid & bus.issue_ready & is_branch & ~flush;
        new_entry.btype = bus.issue_type;
        new_entry.idx   = bus.issue_idx;
        new_entry.pred  = bus.issue_pred;
    end

    // Queue pointers and occupancy; a flush empties the queue outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
        end
    end

    // Queue storage; contents are only meaningful under the occupancy count
    always_ff @(posedge clk) begin
        if (do_push) fifo_q[wr_ptr_q] <= new_entry;
    end

    // BHT training on conditional resolves, saturating at 00 and 11
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_N; i++) bht_q[i] <= 2'b01;
        end else if (do_pop && head_cond) begin
            if (bus.resolve_taken) begin
                if (bht_q[head.idx] != 2'b11) bht_q[head.idx] <= bht_q[head.idx] + 2'b01;
            end else begin
                if (bht_q[head.idx] != 2'b00) bht_q[head.idx] <= bht_q[head.idx] - 2'b01;
            end
        end
    end

    // Registered mispredict pulse and sticky empty-resolve error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
        end else begin
            mispredict <= flush;
            if (bus.resolve_valid && fifo_empty) resolve_err <= 1'b1;
        end
    end

    assign inflight = count_q;
endmodule
